// File: rtl/updown_mon_pkg.sv
// Shared types and constants for the up/down sequence monitor:
// FSM state encoding, direction codes and the 2-bit seven-segment table.
package updown_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Active-low segments, bit 6 = a ... bit 0 = g. Index is the digit 0..3.
  localparam logic [3:0][6:0] SEG_TABLE = {7'h06, 7'h12, 7'h4F, 7'h01};
  localparam logic [6:0]      SEG_OFF   = 7'h7F;

endpackage

// File: rtl/seg7_dec2.sv
// Combinational decode of a 2-bit value to an active-low 7-segment pattern.
module seg7_dec2
  import updown_mon_pkg::*;
(
  input  logic [1:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/updown_seq_monitor.sv
// Monitors a free-running 2-bit up/down counter: checks each step against
// the value predicted from the previous sample and mode, reports wraps and
// step errors, and latches a sticky fault after ERR_LIMIT consecutive errors.
// Optional feature: define UPDOWN_MON_SEG_EN to drive a 7-segment view of q;
// without it seg is held dark.
module updown_seq_monitor
  import updown_mon_pkg::*;
#(
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              m,
  input  logic [1:0]        q,
  input  logic              clr,
  output logic              dir,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [3:0]        err_cnt,
  output logic              fault,
  output logic [6:0]        seg
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [3:0]        ERR_LIM4 = 4'(ERR_LIMIT);

  mon_state_e        state_q, state_d;
  logic [1:0]        prev_q_q, prev_q_d;
  logic              prev_m_q, prev_m_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic [3:0]        err_cnt_q, err_cnt_d;
  logic              fault_q, fault_d;
  logic [1:0]        exp_q;
  logic              step_wraps;

  // Next-state: capture a reference, then compare every enabled step to it.
  always_comb begin
    state_d    = state_q;
    prev_q_d   = prev_q_q;
    prev_m_d   = prev_m_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_cnt_d  = err_cnt_q;
    fault_d    = fault_q;
    exp_q      = prev_q_q + ((prev_m_q == DIR_DOWN) ? 2'd3 : 2'd1);
    // A correct step wraps only when leaving the end of its own direction.
    step_wraps = (prev_m_q == DIR_UP) ? (prev_q_q == 2'd3) : (prev_q_q == 2'd0);

    if (clr) begin
      // Clear wins over whatever the current step would have reported.
      fault_d    = 1'b0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
      state_d    = IDLE;
    end else if (!en) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      prev_q_d = q;
      prev_m_d = m;
      state_d  = TRACK;
    end else begin
      // Always re-anchor on the new sample so one glitch costs one error.
      prev_q_d = q;
      prev_m_d = m;
      if (q == exp_q) begin
        err_cnt_d = '0;
        dir_d     = prev_m_q;
        if (step_wraps) begin
          wrap_d = 1'b1;
          if (wrap_cnt_q != WRAP_MAX) wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_d >= ERR_LIM4) fault_d = 1'b1;
      end
      state_d = fault_d ? FAULT : TRACK;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q_q   <= 2'd0;
      prev_m_q   <= DIR_UP;
      dir_q      <= DIR_UP;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q_q   <= prev_q_d;
      prev_m_q   <= prev_m_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign dir      = dir_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign fault    = fault_q;

`ifdef UPDOWN_MON_SEG_EN
  logic [6:0] seg_dec;
  logic [6:0] seg_q;

  seg7_dec2 u_seg7_dec2 (
    .digit_i (q),
    .seg_o   (seg_dec)
  );

  // Display register: shows the last q sampled while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  seg_q <= SEG_TABLE[0];
    else if (en) seg_q <= seg_dec;
  end

  assign seg = seg_q;
`else
  assign seg = SEG_OFF;
`endif

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Bench for updown_seq_monitor: directed scenarios followed by random steps,
// all checked against a step-level reference model. A second instance with
// WRAP_W=2 shares the stimulus to observe wrap-count saturation.
module tb_updown_seq_monitor;

  logic       clk = 1'b0;
  logic       reset, en, m, clr;
  logic [1:0] q;

  logic       dir, wrap, err, fault;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;
  logic [6:0] seg;

  logic       dir2, wrap2, err2, fault2;
  logic [1:0] wrap_cnt2;
  logic [3:0] err_cnt2;
  logic [6:0] seg2;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit       r_have;
  int       r_pq;
  bit       r_pm;
  bit       r_dir, r_wrap, r_err, r_fault;
  int       r_errs;
  int       r_wraps;
  logic [6:0] r_seg;

  always #5 clk = ~clk;

  updown_seq_monitor #(.WRAP_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .en(en), .m(m), .q(q), .clr(clr),
    .dir(dir), .wrap(wrap), .wrap_cnt(wrap_cnt), .err(err),
    .err_cnt(err_cnt), .fault(fault), .seg(seg)
  );

  updown_seq_monitor #(.WRAP_W(2), .ERR_LIMIT(3)) dut_w2 (
    .clk(clk), .reset(reset), .en(en), .m(m), .q(q), .clr(clr),
    .dir(dir2), .wrap(wrap2), .wrap_cnt(wrap_cnt2), .err(err2),
    .err_cnt(err_cnt2), .fault(fault2), .seg(seg2)
  );

  function automatic logic [6:0] seg_ref(input logic [1:0] d);
    case (d)
      2'd0:    return 7'h01;
      2'd1:    return 7'h4F;
      2'd2:    return 7'h12;
      default: return 7'h06;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    r_have = 0; r_pq = 0; r_pm = 0; r_dir = 0; r_wrap = 0; r_err = 0;
    r_fault = 0; r_errs = 0; r_wraps = 0;
`ifdef UPDOWN_MON_SEG_EN
    r_seg = 7'h01;
`else
    r_seg = 7'h7F;
`endif
  endtask

  task automatic model_step(input bit e, input bit mm, input logic [1:0] qq, input bit c);
    int nxt;
    r_wrap = 0;
    r_err  = 0;
`ifdef UPDOWN_MON_SEG_EN
    if (e) r_seg = seg_ref(qq);
`endif
    if (c) begin
      r_fault = 0; r_errs = 0; r_wraps = 0; r_have = 0;
    end else if (!e) begin
      r_have = 0;
    end else if (!r_have) begin
      r_have = 1; r_pq = int'(qq); r_pm = mm;
    end else begin
      nxt = r_pq + (r_pm ? -1 : 1);
      if (((nxt + 4) % 4) == int'(qq)) begin
        r_dir  = r_pm;
        r_errs = 0;
        if (nxt < 0 || nxt > 3) begin
          r_wrap = 1;
          r_wraps++;
        end
      end else begin
        r_err = 1;
        if (r_errs < 15) r_errs++;
        if (r_errs >= 3) r_fault = 1;
      end
      r_pq = int'(qq);
      r_pm = mm;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".dir"},      dir,       r_dir);
    chk({ctx, ".wrap"},     wrap,      r_wrap);
    chk({ctx, ".err"},      err,       r_err);
    chk({ctx, ".err_cnt"},  err_cnt,   r_errs);
    chk({ctx, ".fault"},    fault,     r_fault);
    chk({ctx, ".wrap_cnt"}, wrap_cnt,  (r_wraps > 255) ? 255 : r_wraps);
    chk({ctx, ".wrap_cnt2"}, wrap_cnt2, (r_wraps > 3) ? 3 : r_wraps);
    chk({ctx, ".seg"},      seg,       r_seg);
  endtask

  task automatic step(input bit e, input bit mm, input logic [1:0] qq, input bit c, input string ctx);
    @(negedge clk);
    en = e; m = mm; q = qq; clr = c;
    @(posedge clk);
    model_step(e, mm, qq, c);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [1:0] rq;
    bit         re, rm, rc;

    reset = 1'b0; en = 1'b0; m = 1'b0; q = 2'd0; clr = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // up run with one wrap
    step(1, 0, 2'd0, 0, "up0");
    step(1, 0, 2'd1, 0, "up1");
    step(1, 0, 2'd2, 0, "up2");
    step(1, 0, 2'd3, 0, "up3");
    step(1, 0, 2'd0, 0, "up4");
    chk("up_wrap_pulse", wrap, 1'b1);
    step(1, 0, 2'd1, 0, "up5");
    chk("up_wrap_cnt", wrap_cnt, 8'd1);
    chk("up_dir", dir, 1'b0);

    // down run with one wrap
    step(0, 0, 2'd0, 1, "clr_a");
    step(1, 1, 2'd2, 0, "dn0");
    step(1, 1, 2'd1, 0, "dn1");
    step(1, 1, 2'd0, 0, "dn2");
    step(1, 1, 2'd3, 0, "dn3");
    chk("dn_wrap_pulse", wrap, 1'b1);
    chk("dn_dir", dir, 1'b1);
    chk("dn_wrap_cnt", wrap_cnt, 8'd1);

    // single glitch costs one error
    step(0, 0, 2'd0, 1, "clr_b");
    step(1, 0, 2'd0, 0, "gl0");
    step(1, 0, 2'd1, 0, "gl1");
    step(1, 0, 2'd3, 0, "gl2");
    chk("gl_err_cnt1", err_cnt, 4'd1);
    step(1, 0, 2'd0, 0, "gl3");
    chk("gl_err_cnt0", err_cnt, 4'd0);
    chk("gl_fault", fault, 1'b0);

    // stuck counter drives fault, clr recovers
    step(0, 0, 2'd0, 1, "clr_c");
    for (int i = 0; i < 5; i++) step(1, 0, 2'd2, 0, "stk");
    chk("stk_fault", fault, 1'b1);
    step(1, 0, 2'd2, 1, "stk_clr");
    chk("clr_fault", fault, 1'b0);
    chk("clr_err_cnt", err_cnt, 4'd0);
    step(1, 0, 2'd2, 0, "post_clr_capture");
    chk("post_clr_no_err", err, 1'b0);

    // reset mid-run, then en low/high
    step(1, 0, 2'd3, 0, "pre_rst0");
    step(1, 0, 2'd0, 0, "pre_rst1");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_seg", seg, r_seg);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 2'd1, 0, "rst_capture");
    chk("rst_capture_err", err, 1'b0);
    step(1, 0, 2'd2, 0, "rst_track");
    step(0, 0, 2'd0, 0, "en_low");
    step(1, 0, 2'd3, 0, "en_capture");
    chk("en_capture_err", err, 1'b0);
    step(1, 0, 2'd0, 0, "en_track");

    // five up wraps saturate the narrow counter
    step(0, 0, 2'd0, 1, "clr_d");
    step(1, 0, 2'd0, 0, "sat_cap");
    for (int w = 0; w < 5; w++) begin
      step(1, 0, 2'd1, 0, "sat");
      step(1, 0, 2'd2, 0, "sat");
      step(1, 0, 2'd3, 0, "sat");
      step(1, 0, 2'd0, 0, "sat");
    end
    chk("sat_w2", wrap_cnt2, 2'd3);
    chk("sat_w8", wrap_cnt, 8'd5);
    step(1, 0, 2'd1, 0, "seg1");
    step(1, 0, 2'd2, 0, "seg2");
`ifdef UPDOWN_MON_SEG_EN
    chk("seg_q2", seg, 7'h12);
`else
    chk("seg_off", seg, 7'h7F);
`endif

    // random stepping against the model
    for (int k = 0; k < 400; k++) begin
      re = ($urandom_range(0, 99) >= 5);
      rc = ($urandom_range(0, 99) < 3);
      rm = ($urandom_range(0, 99) < 10) ? ~r_pm : r_pm;
      if (r_have && $urandom_range(0, 99) < 85)
        rq = 2'((r_pq + (r_pm ? 3 : 1)) % 4);
      else
        rq = 2'($urandom_range(0, 3));
      step(re, rm, rq, rc, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
